// File: rtl/hilo_ctrl_pkg.sv
// Shared HI/LO definitions for the EX-stage multiply/divide front-end.
// Contents:
//   HL_*       : EX-stage HI/LO op codes (9..15 decode as NOP)
//   MD_*       : bit positions inside md_op {signed, mul start, div start}
//   St*        : hilo_ctrl FSM state encodings
//   is_*_op    : op-class decode helpers
package hilo_ctrl_pkg;

  localparam logic [3:0] HL_NOP   = 4'd0;
  localparam logic [3:0] HL_MULT  = 4'd1;
  localparam logic [3:0] HL_MULTU = 4'd2;
  localparam logic [3:0] HL_DIV   = 4'd3;
  localparam logic [3:0] HL_DIVU  = 4'd4;
  localparam logic [3:0] HL_MTHI  = 4'd5;
  localparam logic [3:0] HL_MTLO  = 4'd6;
  localparam logic [3:0] HL_MFHI  = 4'd7;
  localparam logic [3:0] HL_MFLO  = 4'd8;

  localparam int unsigned MD_SIGNED = 2;
  localparam int unsigned MD_MUL    = 1;
  localparam int unsigned MD_DIV    = 0;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMulWait = 2'd1;
  localparam logic [1:0] StDivWait = 2'd2;

  // Any op that reads or writes HI/LO.
  function automatic logic is_hl_op(input logic [3:0] op);
    return (op >= HL_MULT) && (op <= HL_MFLO);
  endfunction

  // Ops that issue to mul_div.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= HL_MULT) && (op <= HL_DIVU);
  endfunction

  function automatic logic is_mf_op(input logic [3:0] op);
    return (op == HL_MFHI) || (op == HL_MFLO);
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO controller and issue front-end for the shared mul_div unit.
// Issues one md_op pulse per MULT/MULTU/DIV/DIVU, waits for the result, writes it to HI/LO,
// handles MTHI/MTLO/MFHI/MFLO, stalls EX on HI/LO hazards and bypasses the result to an MF
// presented in the capture cycle.
// Ports:
//   clk, rst_p            : clock, synchronous active-high reset
//   ex_valid, ex_cancel   : EX instruction valid / being flushed
//   ex_op, ex_rs, ex_rt   : HI/LO op code and operands
//   stall                 : hold EX this cycle
//   mf_data               : MFHI/MFLO result, valid when !stall
//   md_a, md_b, md_op     : operands and {signed, mul, div} start to mul_div
//   md_done, md_res       : mul_div completion and {HI, LO} result
//   hi, lo                : architectural HI/LO
module hilo_ctrl
  import hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_p,
  input  logic        ex_valid,
  input  logic        ex_cancel,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [2:0]  md_op,
  input  logic        md_done,
  input  logic [63:0] md_res,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state_q, state_d;
  logic        seen_busy_q, seen_busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic capture;
  logic accept;
  logic op_hl, op_md, op_mf;

  assign op_hl = is_hl_op(ex_op);
  assign op_md = is_md_op(ex_op);
  assign op_mf = is_mf_op(ex_op);

  // A divide only completes once mul_div has been seen busy; this rejects the stale done
  // still asserted in the first wait cycle.
  assign capture = (state_q == StMulWait) ||
                   ((state_q == StDivWait) && md_done && seen_busy_q);

  always_comb begin
    stall = 1'b0;
    if (state_q != StIdle) begin
      stall = ex_valid && op_hl && !(capture && op_mf);
    end else begin
      stall = ex_valid && op_md && !md_done;
    end
  end

  assign accept = ex_valid && !ex_cancel && !stall;

  assign md_a = ex_rs;
  assign md_b = ex_rt;

  always_comb begin
    md_op = 3'b000;
    if ((state_q == StIdle) && accept) begin
      case (ex_op)
        HL_MULT:  begin md_op[MD_SIGNED] = 1'b1; md_op[MD_MUL] = 1'b1; end
        HL_MULTU: md_op[MD_MUL] = 1'b1;
        HL_DIV:   begin md_op[MD_SIGNED] = 1'b1; md_op[MD_DIV] = 1'b1; end
        HL_DIVU:  md_op[MD_DIV] = 1'b1;
        default:  md_op = 3'b000;
      endcase
    end
  end

  // In the capture cycle the freshly produced result is forwarded ahead of the HI/LO write.
  always_comb begin
    mf_data = 32'h0;
    if (ex_op == HL_MFHI) begin
      mf_data = capture ? md_res[63:32] : hi_q;
    end else if (ex_op == HL_MFLO) begin
      mf_data = capture ? md_res[31:0] : lo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      StIdle: begin
        seen_busy_d = 1'b0;
        if (accept) begin
          case (ex_op)
            HL_MULT, HL_MULTU: state_d = StMulWait;
            HL_DIV, HL_DIVU:   state_d = StDivWait;
            HL_MTHI:           hi_d = ex_rs;
            HL_MTLO:           lo_d = ex_rs;
            default:           ;
          endcase
        end
      end
      StMulWait: begin
        hi_d    = md_res[63:32];
        lo_d    = md_res[31:0];
        state_d = StIdle;
      end
      StDivWait: begin
        if (!md_done) begin
          seen_busy_d = 1'b1;
        end
        if (capture) begin
          hi_d        = md_res[63:32];
          lo_d        = md_res[31:0];
          seen_busy_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q     <= StIdle;
      seen_busy_q <= 1'b0;
      hi_q        <= 32'h0;
      lo_q        <= 32'h0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with a behavioural stand-in for mul_div:
// multiply result is ready the cycle after issue, divide drops done for 31 cycles and
// raises it with the result 32 cycles after issue.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic        clk;
  logic        rst_p;
  logic        ex_valid;
  logic        ex_cancel;
  logic [3:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [2:0]  md_op;
  logic        md_done;
  logic [63:0] md_res;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_ctrl u_dut (
    .clk      (clk),
    .rst_p    (rst_p),
    .ex_valid (ex_valid),
    .ex_cancel(ex_cancel),
    .ex_op    (ex_op),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .stall    (stall),
    .mf_data  (mf_data),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_op    (md_op),
    .md_done  (md_done),
    .md_res   (md_res),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mul_div stand-in.
  logic [5:0] div_cnt;
  assign md_done = (div_cnt == 6'd0);

  always @(posedge clk) begin
    if (rst_p) begin
      div_cnt <= 6'd0;
      md_res  <= 64'h0;
    end else if (md_op[MD_MUL]) begin
      if (md_op[MD_SIGNED]) md_res <= {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
      else                  md_res <= {32'h0, md_a} * {32'h0, md_b};
    end else if (md_op[MD_DIV]) begin
      div_cnt <= 6'd31;
      if (md_b == 32'h0)        md_res <= {md_a, 32'hFFFF_FFFF};
      else if (md_op[MD_SIGNED]) md_res <= {32'($signed(md_a) % $signed(md_b)),
                                            32'($signed(md_a) / $signed(md_b))};
      else                      md_res <= {md_a % md_b, md_a / md_b};
    end else if (div_cnt != 6'd0) begin
      div_cnt <= div_cnt - 6'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    ex_valid = v;
    ex_op    = op;
    ex_rs    = rs;
    ex_rt    = rt;
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    ex_cancel = 1'b0;
    step();
    step();
    drive(1'b1, HL_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++;
    if (md_op !== 3'b000) begin n_fail++; $display("FAIL reset_md_op got %b want 000", md_op); end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    n_checks++;
    if (mf_data !== 32'h0) begin n_fail++; $display("FAIL reset_mf got %h want 0", mf_data); end
    step();
    rst_p = 1'b0;
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
  endtask

  task automatic test_mult();
    step();
    drive(1'b1, HL_MULT, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || md_op !== 3'b110) begin
      n_fail++; $display("FAIL mult_issue got stall=%b md_op=%b want 0/110", stall, md_op);
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (md_op !== 3'b000) begin n_fail++; $display("FAIL mult_pulse got %b want 000", md_op); end
    step();
    @(negedge clk);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffffe", hi, lo);
    end
  endtask

  task automatic test_multu_bypass();
    step();
    drive(1'b1, HL_MULTU, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    n_checks++;
    if (md_op !== 3'b010) begin n_fail++; $display("FAIL multu_issue got %b want 010", md_op); end
    step();
    drive(1'b1, HL_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || mf_data !== 32'h1) begin
      n_fail++; $display("FAIL multu_bypass got stall=%b mf=%h want 0/1", stall, mf_data);
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu_hilo got %h/%h want 1/fffffffe", hi, lo);
    end
  endtask

  task automatic test_div_stall();
    step();
    drive(1'b1, HL_DIV, 32'hFFFF_FFF9, 32'h2);
    @(negedge clk);
    n_checks++;
    if (md_op !== 3'b101) begin n_fail++; $display("FAIL div_issue got %b want 101", md_op); end
    for (int k = 1; k <= 31; k++) begin
      step();
      drive(1'b1, HL_MFLO, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1 || md_op !== 3'b000) begin
        n_fail++;
        $display("FAIL div_wait_stall T+%0d got stall=%b md_op=%b want 1/000", k, stall, md_op);
      end
    end
    step();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || mf_data !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_bypass got stall=%b mf=%h want 0/fffffffd", stall, mf_data);
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_hilo got %h/%h want ffffffff/fffffffd", hi, lo);
    end
  endtask

  task automatic test_divu_alu();
    step();
    drive(1'b1, HL_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    n_checks++;
    if (md_op !== 3'b001) begin n_fail++; $display("FAIL divu_issue got %b want 001", md_op); end
    for (int k = 1; k <= 32; k++) begin
      step();
      drive(1'b1, (k % 2 == 1) ? 4'd9 : 4'd15, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL divu_alu_nostall T+%0d got %b want 0", k, stall);
      end
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++; $display("FAIL divu_hilo got %h/%h want 2/e", hi, lo);
    end
  endtask

  task automatic test_mt();
    step();
    drive(1'b1, HL_MTHI, 32'h1234_5678, 32'h0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %b want 0", stall); end
    step();
    drive(1'b1, HL_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || mf_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mthi_mfhi got stall=%b mf=%h want 0/12345678", stall, mf_data);
    end
    step();
    ex_cancel = 1'b1;
    drive(1'b1, HL_MTLO, 32'hDEAD_BEEF, 32'h0);
    step();
    ex_cancel = 1'b0;
    drive(1'b1, HL_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (lo !== 32'd14 || mf_data !== 32'd14) begin
      n_fail++; $display("FAIL mtlo_cancel got lo=%h mf=%h want e/e", lo, mf_data);
    end
  endtask

  task automatic test_back_to_back();
    step();
    drive(1'b1, HL_MULT, 32'd3, 32'd5);
    @(negedge clk);
    n_checks++;
    if (md_op !== 3'b110) begin n_fail++; $display("FAIL b2b_mult_issue got %b want 110", md_op); end
    step();
    drive(1'b1, HL_DIVU, 32'd50, 32'd8);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || md_op !== 3'b000) begin
      n_fail++; $display("FAIL b2b_capture_hold got stall=%b md_op=%b want 1/000", stall, md_op);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || md_op !== 3'b001 || hi !== 32'h0 || lo !== 32'd15) begin
      n_fail++;
      $display("FAIL b2b_div_issue got stall=%b md_op=%b hi=%h lo=%h want 0/001/0/f",
               stall, md_op, hi, lo);
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
    for (int k = 2; k <= 33; k++) step();
    @(negedge clk);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd6) begin
      n_fail++; $display("FAIL b2b_div_hilo got %h/%h want 2/6", hi, lo);
    end
  endtask

  task automatic test_reset_mid_div();
    step();
    drive(1'b1, HL_DIV, 32'd100, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      step();
      drive(1'b0, HL_NOP, 32'h0, 32'h0);
    end
    step();
    rst_p = 1'b1;
    step();
    rst_p = 1'b0;
    drive(1'b1, HL_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || mf_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_div_mf got stall=%b mf=%h want 0/0", stall, mf_data);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_div_hilo got %h/%h want 0/0", hi, lo);
    end
    step();
    drive(1'b0, HL_NOP, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_bypass();
    test_div_stall();
    test_divu_alu();
    test_mt();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
